// File: rtl/pipelined_ctrl_pkg.sv
// Shared encodings and pipeline control bundles for the RV32I pipelined control unit.
package pipelined_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // ALU control codes are held at full width internally and truncated at the port.
  localparam int ALUCTRL_MAX_W = 4;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLL  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_IMM = 2'b11;

  typedef struct packed {
    logic                     reg_write;
    logic [1:0]               result_src;
    logic                     mem_write;
    logic                     jump;
    logic                     branch;
    logic [ALUCTRL_MAX_W-1:0] alu_ctrl;
    logic                     alu_src;
    logic                     pc_tgt_src;
    logic [2:0]               funct3;
  } e_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
  } m_ctrl_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } w_ctrl_t;

  // Operations outside the base add/sub/and/or/slt set need the 4-bit ALU.
  function automatic logic alu_needs_wide(input logic [3:0] code);
    return !(code inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT});
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Decode-stage main decoder and ALU decoder (purely combinational).
// Build option BRANCH_FULL_EN: carry funct3 for full branch compare, reject funct3 010/011 on branches.
module ctrl_decode
  import pipelined_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output e_ctrl_t    ctrl,
  output logic [2:0] imm_src,
  output logic       illegal
);

  aluop_e     alu_op;
  logic       op_ok;
  logic       wide_bad;
  logic       br_bad;
  logic [3:0] alu_fn;

  // Main decode, ALU decode and illegal-instruction squash.
  always_comb begin
    ctrl    = '0;
    imm_src = IMM_I;
    alu_op  = ALUOP_ADD;
    op_ok   = 1'b1;
    br_bad  = 1'b0;

    case (op)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_src    = 1'b1;
        imm_src         = IMM_I;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_S;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        alu_op         = ALUOP_FUNCT;
      end
      OP_ITYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        imm_src        = IMM_I;
        alu_op         = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        imm_src     = IMM_B;
        alu_op      = ALUOP_SUB;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
        imm_src         = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.pc_tgt_src = 1'b1;
        imm_src         = IMM_I;
      end
      OP_LUI: begin
        ctrl.reg_write  = 1'b1;
        ctrl.result_src = RES_IMM;
        imm_src         = IMM_U;
      end
      default: op_ok = 1'b0;
    endcase

    // op[5] separates R-type from I-type, so addi with imm bit 30 set stays an add.
    case (funct3)
      3'b000:  alu_fn = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase

    case (alu_op)
      ALUOP_SUB:   ctrl.alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: ctrl.alu_ctrl = alu_fn;
      default:     ctrl.alu_ctrl = ALU_ADD;
    endcase

    wide_bad = (ALUCTRL_W < ALUCTRL_MAX_W) && (alu_op == ALUOP_FUNCT) && alu_needs_wide(alu_fn);

`ifdef BRANCH_FULL_EN
    br_bad      = (op == OP_BRANCH) && ((funct3 == 3'b010) || (funct3 == 3'b011));
    ctrl.funct3 = funct3;
`else
    ctrl.funct3 = 3'b000;
`endif

    illegal = !op_ok || wide_bad || br_bad;
    if (illegal) begin
      ctrl    = '0;
      imm_src = IMM_I;
    end
  end

endmodule

// File: rtl/pipelined_controller.sv
// RV32I five-stage control unit: Decode -> E/M/W control pipeline and Execute redirect.
// Build option BRANCH_FULL_EN: all six branch conditions from N/Z/C/V; otherwise every branch is beq.
module pipelined_controller
  import pipelined_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 3,
  parameter int IMMSRC_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opD,
  input  logic [2:0]           funct3D,
  input  logic                 funct7b5D,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic                 ZeroE,
  input  logic                 NegE,
  input  logic                 CarryE,
  input  logic                 OverflowE,
  output logic [IMMSRC_W-1:0]  ImmSrcD,
  output logic                 IllegalD,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcE,
  output logic                 ResultSrcE0,
  output logic                 PCSrcE,
  output logic                 PCTargetSrcE,
  output logic                 MemWriteM,
  output logic                 RegWriteM,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW
);

  e_ctrl_t    dec_ctrl;
  logic [2:0] imm_src_raw;
  e_ctrl_t    e_d, e_q;
  m_ctrl_t    m_d, m_q;
  w_ctrl_t    w_d, w_q;
  logic       taken;
  logic       unused_bits;

  ctrl_decode #(.ALUCTRL_W(ALUCTRL_W)) u_decode (
    .op       (opD),
    .funct3   (funct3D),
    .funct7b5 (funct7b5D),
    .ctrl     (dec_ctrl),
    .imm_src  (imm_src_raw),
    .illegal  (IllegalD)
  );

  assign ImmSrcD = IMMSRC_W'(imm_src_raw);

  // Next-state for the pipeline registers; flush beats stall, M->W always advances.
  always_comb begin
    e_d          = dec_ctrl;
    m_d.reg_write  = e_q.reg_write;
    m_d.result_src = e_q.result_src;
    m_d.mem_write  = e_q.mem_write;
    if (FlushE) begin
      e_d = '0;
    end else if (StallE) begin
      e_d = e_q;
      m_d = '0;
    end
    w_d.reg_write  = m_q.reg_write;
    w_d.result_src = m_q.result_src;
  end

  // Pipeline registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  // Branch condition and Execute-stage redirect; a bubble has jump=branch=0.
  always_comb begin
`ifdef BRANCH_FULL_EN
    case (e_q.funct3)
      3'b000:  taken = ZeroE;
      3'b001:  taken = !ZeroE;
      3'b100:  taken = NegE ^ OverflowE;
      3'b101:  taken = !(NegE ^ OverflowE);
      3'b110:  taken = !CarryE;
      3'b111:  taken = CarryE;
      default: taken = 1'b0;
    endcase
`else
    taken = ZeroE;
`endif
    PCSrcE = e_q.jump | (e_q.branch & taken);
  end

  assign ALUControlE  = e_q.alu_ctrl[ALUCTRL_W-1:0];
  assign ALUSrcE      = e_q.alu_src;
  assign ResultSrcE0  = e_q.result_src[0];
  assign PCTargetSrcE = e_q.pc_tgt_src;
  assign MemWriteM    = m_q.mem_write;
  assign RegWriteM    = m_q.reg_write;
  assign RegWriteW    = w_q.reg_write;
  assign ResultSrcW   = w_q.result_src;

  // Flags and funct3 are dead in the beq-only build; upper ALU bit is dead at width 3.
  assign unused_bits = ^{NegE, CarryE, OverflowE, e_q.funct3, e_q.alu_ctrl};

endmodule

// File: tb/tb_pipelined_controller.sv
// Self-checking bench for pipelined_controller: directed scenarios plus random instruction stream.
module tb_pipelined_controller;

  localparam int AW = 3;
  localparam int IW = 3;

  localparam int A_ADD = 0, A_SUB = 1, A_AND = 2, A_OR = 3, A_XOR = 4;
  localparam int A_SLT = 5, A_SLL = 6, A_SLTU = 7, A_SRL = 8, A_SRA = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opD;
  logic [2:0]    funct3D;
  logic          funct7b5D, StallE, FlushE, ZeroE, NegE, CarryE, OverflowE;
  logic [IW-1:0] ImmSrcD;
  logic          IllegalD;
  logic [AW-1:0] ALUControlE;
  logic          ALUSrcE, ResultSrcE0, PCSrcE, PCTargetSrcE;
  logic          MemWriteM, RegWriteM, RegWriteW;
  logic [1:0]    ResultSrcW;

  pipelined_controller #(.ALUCTRL_W(AW), .IMMSRC_W(IW)) dut (
    .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
    .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE), .NegE(NegE), .CarryE(CarryE),
    .OverflowE(OverflowE), .ImmSrcD(ImmSrcD), .IllegalD(IllegalD), .ALUControlE(ALUControlE),
    .ALUSrcE(ALUSrcE), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .PCTargetSrcE(PCTargetSrcE),
    .MemWriteM(MemWriteM), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // What an instruction means, independent of how the DUT encodes it internally.
  typedef struct {
    bit       legal;
    bit       rw;
    bit [1:0] rs;
    bit       mw;
    bit       jmp;
    bit       br;
    int       alu;
    bit       asrc;
    bit       ptgt;
    int       imm;
    bit       imm_used;
    bit [2:0] f3;
  } rec_t;

  rec_t     e_s;
  bit       m_rw, m_mw, m_care;
  bit [1:0] m_rs;
  bit       w_rw, w_care;
  bit [1:0] w_rs;

  function automatic rec_t bubble();
    rec_t r;
    r.legal = 1; r.rw = 0; r.rs = 0; r.mw = 0; r.jmp = 0; r.br = 0;
    r.alu = 0; r.asrc = 0; r.ptgt = 0; r.imm = 0; r.imm_used = 0; r.f3 = 0;
    return r;
  endfunction

  function automatic int alu_of(bit [2:0] f3, bit is_r, bit f7);
    case (f3)
      3'd0: return (is_r && f7) ? A_SUB : A_ADD;
      3'd1: return A_SLL;
      3'd2: return A_SLT;
      3'd3: return A_SLTU;
      3'd4: return A_XOR;
      3'd5: return f7 ? A_SRA : A_SRL;
      3'd6: return A_OR;
      default: return A_AND;
    endcase
  endfunction

  function automatic bit narrow_ok(int fn);
    return (AW >= 4) || (fn == A_ADD) || (fn == A_SUB) || (fn == A_AND) || (fn == A_OR) || (fn == A_SLT);
  endfunction

  function automatic rec_t ref_decode(bit [6:0] op, bit [2:0] f3, bit f7);
    rec_t r = bubble();
    case (op)
      7'h03: begin r.rw = 1; r.rs = 1; r.asrc = 1; r.imm = 0; r.imm_used = 1; r.alu = A_ADD; end
      7'h23: begin r.mw = 1; r.asrc = 1; r.imm = 1; r.imm_used = 1; r.alu = A_ADD; end
      7'h33: begin r.rw = 1; r.alu = alu_of(f3, 1, f7); r.legal = narrow_ok(r.alu); end
      7'h13: begin r.rw = 1; r.asrc = 1; r.imm = 0; r.imm_used = 1;
                   r.alu = alu_of(f3, 0, f7); r.legal = narrow_ok(r.alu); end
      7'h63: begin
        r.br = 1; r.imm = 2; r.imm_used = 1; r.alu = A_SUB; r.f3 = f3;
`ifdef BRANCH_FULL_EN
        if (f3 == 3'd2 || f3 == 3'd3) r.legal = 0;
`endif
      end
      7'h6F: begin r.rw = 1; r.rs = 2; r.jmp = 1; r.imm = 3; r.imm_used = 1; end
      7'h67: begin r.rw = 1; r.rs = 2; r.jmp = 1; r.asrc = 1; r.ptgt = 1;
                   r.imm = 0; r.imm_used = 1; r.alu = A_ADD; end
      7'h37: begin r.rw = 1; r.rs = 3; r.imm = 4; r.imm_used = 1; end
      default: r.legal = 0;
    endcase
    if (!r.legal) begin r.rw = 0; r.mw = 0; r.jmp = 0; r.br = 0; end
    return r;
  endfunction

  function automatic bit ref_taken(bit [2:0] f3, bit z, bit n, bit c, bit v);
`ifdef BRANCH_FULL_EN
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n ^ v;
      3'd5: return !(n ^ v);
      3'd6: return !c;
      3'd7: return c;
      default: return 0;
    endcase
`else
    return z;
`endif
  endfunction

  task automatic model_reset();
    e_s = bubble();
    m_rw = 0; m_mw = 0; m_rs = 0; m_care = 1;
    w_rw = 0; w_rs = 0; w_care = 1;
  endtask

  task automatic model_clock();
    rec_t d = ref_decode(opD, funct3D, funct7b5D);
    w_rw = m_rw; w_rs = m_rs; w_care = m_care;
    if (FlushE) begin
      m_rw = e_s.rw; m_mw = e_s.mw; m_rs = e_s.rs; m_care = e_s.legal;
      e_s = bubble();
    end else if (StallE) begin
      m_rw = 0; m_mw = 0; m_rs = 0; m_care = 1;
    end else begin
      m_rw = e_s.rw; m_mw = e_s.mw; m_rs = e_s.rs; m_care = e_s.legal;
      e_s = d;
    end
  endtask

  task automatic check_outputs();
    rec_t d = ref_decode(opD, funct3D, funct7b5D);
    chk("IllegalD", 32'(IllegalD), 32'(!d.legal));
    if (d.legal && d.imm_used) chk("ImmSrcD", 32'(ImmSrcD), 32'(d.imm));
    chk("PCSrcE", 32'(PCSrcE), 32'(e_s.jmp | (e_s.br & ref_taken(e_s.f3, ZeroE, NegE, CarryE, OverflowE))));
    if (e_s.legal) begin
      chk("ALUControlE", 32'(ALUControlE), 32'(e_s.alu));
      chk("ALUSrcE", 32'(ALUSrcE), 32'(e_s.asrc));
      chk("PCTargetSrcE", 32'(PCTargetSrcE), 32'(e_s.ptgt));
      chk("ResultSrcE0", 32'(ResultSrcE0), 32'(e_s.rs[0]));
    end
    chk("RegWriteM", 32'(RegWriteM), 32'(m_rw));
    chk("MemWriteM", 32'(MemWriteM), 32'(m_mw));
    chk("RegWriteW", 32'(RegWriteW), 32'(w_rw));
    if (w_care) chk("ResultSrcW", 32'(ResultSrcW), 32'(w_rs));
  endtask

  // Called one time unit after a rising edge; returns one time unit after the next one.
  task automatic step(input bit [6:0] op, input bit [2:0] f3, input bit f7,
                      input bit st, input bit fl, input bit z, input bit n, input bit c, input bit v);
    opD = op; funct3D = f3; funct7b5D = f7; StallE = st; FlushE = fl;
    ZeroE = z; NegE = n; CarryE = c; OverflowE = v;
    #2;
    check_outputs();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic step_i(input logic [31:0] ins, input bit st, input bit fl);
    step(ins[6:0], ins[14:12], ins[30], st, fl, 0, 0, 0, 0);
  endtask

  localparam logic [31:0] I_ADD  = 32'h003100B3;
  localparam logic [31:0] I_NOP  = 32'h00000013;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_BLT  = 32'h0020C463;
  localparam logic [31:0] I_JAL  = 32'h0080006F;
  localparam logic [31:0] I_SW   = 32'h00112023;
  localparam logic [31:0] I_LW   = 32'h00012083;

  bit [6:0] ops [8] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37};

  initial begin
    reset = 0; opD = 0; funct3D = 0; funct7b5D = 0; StallE = 0; FlushE = 0;
    ZeroE = 0; NegE = 0; CarryE = 0; OverflowE = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    chk("rst_ResultSrcW", 32'(ResultSrcW), 32'd0);
    reset = 1;

    // add flows through E/M/W with fixed latency
    step_i(I_ADD, 0, 0);
    chk("t2_alu_e", 32'(ALUControlE), 32'd0);
    step_i(I_NOP, 0, 0);
    chk("t2_rw_m", 32'(RegWriteM), 32'd1);
    step_i(I_NOP, 0, 0);
    chk("t2_rw_w", 32'(RegWriteW), 32'd1);
    chk("t2_rs_w", 32'(ResultSrcW), 32'd0);

    // asynchronous reset mid-stream with jal in E and add in W
    step_i(I_ADD, 0, 0);
    step_i(I_NOP, 0, 0);
    step_i(I_JAL, 0, 0);
    chk("t1_pre_rww", 32'(RegWriteW), 32'd1);
    chk("t1_pre_pcsrc", 32'(PCSrcE), 32'd1);
    reset = 0;
    #1;
    chk("t1_alu", 32'(ALUControlE), 32'd0);
    chk("t1_alusrc", 32'(ALUSrcE), 32'd0);
    chk("t1_rs0", 32'(ResultSrcE0), 32'd0);
    chk("t1_pcsrc", 32'(PCSrcE), 32'd0);
    chk("t1_ptgt", 32'(PCTargetSrcE), 32'd0);
    chk("t1_mw_m", 32'(MemWriteM), 32'd0);
    chk("t1_rw_m", 32'(RegWriteM), 32'd0);
    chk("t1_rw_w", 32'(RegWriteW), 32'd0);
    chk("t1_rs_w", 32'(ResultSrcW), 32'd0);
    model_reset();
    #3;
    reset = 1;

    // beq resolves on ZeroE; jal always redirects and writes PC+4
    step_i(I_BEQ, 0, 0);
    ZeroE = 1; #1;
    chk("t3_beq_taken", 32'(PCSrcE), 32'd1);
    ZeroE = 0; #1;
    chk("t3_beq_not", 32'(PCSrcE), 32'd0);
    step_i(I_JAL, 0, 0);
    chk("t3_jal_pcsrc", 32'(PCSrcE), 32'd1);
    step_i(I_NOP, 0, 0);
    step_i(I_NOP, 0, 0);
    chk("t3_jal_rs_w", 32'(ResultSrcW), 32'd2);

    // sw held in E by a two-cycle stall; stall+flush clears E
    step_i(I_SW, 0, 0);
    chk("t4_alusrc", 32'(ALUSrcE), 32'd1);
    for (int i = 0; i < 2; i++) begin
      step_i(I_NOP, 1, 0);
      chk("t4_hold_alusrc", 32'(ALUSrcE), 32'd1);
      chk("t4_stall_mw", 32'(MemWriteM), 32'd0);
    end
    step_i(I_NOP, 0, 0);
    chk("t4_release_mw", 32'(MemWriteM), 32'd1);
    step_i(I_LW, 0, 0);
    chk("t4_lw_rs0", 32'(ResultSrcE0), 32'd1);
    step_i(I_NOP, 1, 1);
    chk("t4_sf_alusrc", 32'(ALUSrcE), 32'd0);
    chk("t4_sf_rs0", 32'(ResultSrcE0), 32'd0);

    // unsupported opcode never writes
    opD = 7'h7F; #1;
    chk("t5_illegal", 32'(IllegalD), 32'd1);
    step(7'h7F, 3'd0, 0, 0, 0, 0, 0, 0, 0);
    step_i(I_NOP, 0, 0);
    chk("t5_rw_m", 32'(RegWriteM), 32'd0);
    chk("t5_mw_m", 32'(MemWriteM), 32'd0);
    step_i(I_NOP, 0, 0);
    chk("t5_rw_w", 32'(RegWriteW), 32'd0);

    // blt: signed compare with the full branch unit, plain beq otherwise
    step_i(I_BLT, 0, 0);
`ifdef BRANCH_FULL_EN
    NegE = 1; OverflowE = 0; ZeroE = 0; #1;
    chk("t6_blt_taken", 32'(PCSrcE), 32'd1);
    NegE = 1; OverflowE = 1; #1;
    chk("t6_blt_not", 32'(PCSrcE), 32'd0);
`else
    ZeroE = 1; #1;
    chk("t6_blt_as_beq", 32'(PCSrcE), 32'd1);
    ZeroE = 0; #1;
    chk("t6_blt_as_beq_not", 32'(PCSrcE), 32'd0);
`endif

    // random instruction stream with stalls, flushes and flag noise
    for (int k = 0; k < 400; k++) begin
      int sel;
      bit [6:0] op;
      sel = $urandom_range(0, 9);
      op = (sel < 8) ? ops[sel] : 7'($urandom_range(0, 127));
      step(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
